// File: rtl/wb_chk_pkg.sv
// rtl/wb_chk_pkg.sv - shared FSM encodings and counter constants for the writeback result checker
package wb_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_DONE = 2'd3
   } chk_state_t;

   // Sliced down to the instance counter width; counters stick at all-ones.
   localparam int                    CNT_W_MAX = 64;
   localparam logic [CNT_W_MAX-1:0] CNT_SAT   = '1;

endpackage

// File: rtl/wb_chk_fifo.sv
// rtl/wb_chk_fifo.sv - synchronous FIFO holding {expected, mask} entries for the result checker
module wb_chk_fifo #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int             AW      = $clog2(DEPTH);
   localparam logic [AW:0]    PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // The pointer MSB tells a full lap apart from an empty queue.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/wb_result_checker.sv
// rtl/wb_result_checker.sv - compares retired writeback results against a queue of masked expected values
module wb_result_checker
   import wb_chk_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 32,
   parameter int STOP_ON_ERR = 1,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              exp_valid,
   output logic              exp_ready,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [DATA_W-1:0] exp_mask,
   input  logic              obs_valid,
   input  logic [DATA_W-1:0] obs_data,
   input  logic              end_test,
   output logic [1:0]        state_o,
   output logic              err_flag,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [CNT_W-1:0]  mis_cnt,
   output logic [CNT_W-1:0]  unf_cnt,
   output logic [CNT_W-1:0]  first_idx,
   output logic [DATA_W-1:0] first_exp,
   output logic [DATA_W-1:0] first_obs,
   output logic              done
);

   chk_state_t          state;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic                obs_run;
   logic                unf;
   logic                hit;
   logic                mis;
   logic [2*DATA_W-1:0] head;
   logic [DATA_W-1:0]   head_exp;
   logic [DATA_W-1:0]   head_mask;
   logic [CNT_W-1:0]    obs_idx;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT[CNT_W-1:0]) ? v : v + CNT_W'(1);
   endfunction

   wb_chk_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*DATA_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({exp_data, exp_mask}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_exp  = head[2*DATA_W-1:DATA_W];
   assign head_mask = head[DATA_W-1:0];
   assign exp_ready = ~fifo_full;
   assign fifo_push = exp_valid & ~fifo_full & ((state == ST_IDLE) || (state == ST_RUN));
   assign obs_run   = obs_valid & (state == ST_RUN);
   assign fifo_pop  = obs_run & ~fifo_empty;
   assign unf       = obs_run & fifo_empty;
   assign hit       = ((obs_data ^ head_exp) & head_mask) == '0;
   assign mis       = fifo_pop & ~hit;
   assign state_o   = state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         err_flag  <= 1'b0;
         match_cnt <= '0;
         mis_cnt   <= '0;
         unf_cnt   <= '0;
         obs_idx   <= '0;
         first_idx <= '0;
         first_exp <= '0;
         first_obs <= '0;
         done      <= 1'b0;
      end else begin
         if (obs_run) obs_idx <= sat_inc(obs_idx);
         if (fifo_pop && hit) match_cnt <= sat_inc(match_cnt);
         if (mis) begin
            mis_cnt  <= sat_inc(mis_cnt);
            err_flag <= 1'b1;
            // A saturated mis_cnt never returns to zero, so only the first mismatch lands here.
            if (mis_cnt == '0) begin
               first_idx <= obs_idx;
               first_exp <= head_exp;
               first_obs <= obs_data;
            end
         end
         if (unf) begin
            unf_cnt  <= sat_inc(unf_cnt);
            err_flag <= 1'b1;
         end
         case (state)
            ST_IDLE: if (start) state <= ST_RUN;
            ST_RUN: begin
               if (mis && (STOP_ON_ERR != 0)) begin
                  state <= ST_HALT;
                  done  <= 1'b1;
               end else if (end_test && fifo_empty && !obs_valid) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_result_checker.sv
// tb/tb_wb_result_checker.sv - bench for wb_result_checker with stop-on-error and keep-going instances
module tb_wb_result_checker;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic          start;
   logic          exp_valid;
   logic [DW-1:0] exp_data;
   logic [DW-1:0] exp_mask;
   logic          obs_valid;
   logic [DW-1:0] obs_data;
   logic          end_test;

   logic          exp_ready [2];
   logic [1:0]    state_o   [2];
   logic          err_flag  [2];
   logic [CW-1:0] match_cnt [2];
   logic [CW-1:0] mis_cnt   [2];
   logic [CW-1:0] unf_cnt   [2];
   logic [CW-1:0] first_idx [2];
   logic [DW-1:0] first_exp [2];
   logic [DW-1:0] first_obs [2];
   logic          done      [2];

   int n_chk;
   int n_pass;

   // Reference model: one queue of {expected, mask} per instance plus plain counts.
   logic [63:0] mq [2][$];
   int          m_st    [2];
   int          m_match [2];
   int          m_mis   [2];
   int          m_unf   [2];
   int          m_idx   [2];
   int          m_fidx  [2];
   int          m_err   [2];
   logic [31:0] m_fexp  [2];
   logic [31:0] m_fobs  [2];

   wb_result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .STOP_ON_ERR(1), .CNT_W(CW)) dut_stop (
      .clk(clk), .reset(reset), .start(start),
      .exp_valid(exp_valid), .exp_ready(exp_ready[0]), .exp_data(exp_data), .exp_mask(exp_mask),
      .obs_valid(obs_valid), .obs_data(obs_data), .end_test(end_test),
      .state_o(state_o[0]), .err_flag(err_flag[0]),
      .match_cnt(match_cnt[0]), .mis_cnt(mis_cnt[0]), .unf_cnt(unf_cnt[0]),
      .first_idx(first_idx[0]), .first_exp(first_exp[0]), .first_obs(first_obs[0]),
      .done(done[0])
   );

   wb_result_checker #(.DATA_W(DW), .DEPTH(DEPTH), .STOP_ON_ERR(0), .CNT_W(CW)) dut_cont (
      .clk(clk), .reset(reset), .start(start),
      .exp_valid(exp_valid), .exp_ready(exp_ready[1]), .exp_data(exp_data), .exp_mask(exp_mask),
      .obs_valid(obs_valid), .obs_data(obs_data), .end_test(end_test),
      .state_o(state_o[1]), .err_flag(err_flag[1]),
      .match_cnt(match_cnt[1]), .mis_cnt(mis_cnt[1]), .unf_cnt(unf_cnt[1]),
      .first_idx(first_idx[1]), .first_exp(first_exp[1]), .first_obs(first_obs[1]),
      .done(done[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
   endtask

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   function automatic string nm(input int m);
      return (m == 0) ? "stop" : "cont";
   endfunction

   task automatic model_step(input int m, input bit stop);
      int          sz;
      int          nst;
      logic [63:0] e;
      if (!reset) begin
         mq[m].delete();
         m_st[m] = 0; m_match[m] = 0; m_mis[m] = 0; m_unf[m] = 0;
         m_idx[m] = 0; m_fidx[m] = 0; m_err[m] = 0; m_fexp[m] = 0; m_fobs[m] = 0;
      end else begin
         sz  = mq[m].size();
         nst = m_st[m];
         if (m_st[m] == 1 && obs_valid) begin
            if (sz > 0) begin
               e = mq[m].pop_front();
               if (((obs_data ^ e[63:32]) & e[31:0]) == 32'd0) begin
                  m_match[m] = sat(m_match[m]);
               end else begin
                  if (m_mis[m] == 0) begin
                     m_fidx[m] = m_idx[m];
                     m_fexp[m] = e[63:32];
                     m_fobs[m] = obs_data;
                  end
                  m_mis[m] = sat(m_mis[m]);
                  m_err[m] = 1;
                  if (stop) nst = 2;
               end
            end else begin
               m_unf[m] = sat(m_unf[m]);
               m_err[m] = 1;
            end
            m_idx[m] = sat(m_idx[m]);
         end
         if (m_st[m] == 0 && start) nst = 1;
         if (m_st[m] == 1 && nst == 1 && end_test && sz == 0 && !obs_valid) nst = 3;
         if (sz < DEPTH && exp_valid && m_st[m] <= 1) mq[m].push_back({exp_data, exp_mask});
         m_st[m] = nst;
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         chk({nm(m), ".state"}, 64'(state_o[m]), 64'(m_st[m]));
         chk({nm(m), ".ready"}, 64'(exp_ready[m]), 64'(mq[m].size() < DEPTH));
         chk({nm(m), ".match"}, 64'(match_cnt[m]), 64'(m_match[m]));
         chk({nm(m), ".mis"}, 64'(mis_cnt[m]), 64'(m_mis[m]));
         chk({nm(m), ".unf"}, 64'(unf_cnt[m]), 64'(m_unf[m]));
         chk({nm(m), ".err"}, 64'(err_flag[m]), 64'(m_err[m]));
         chk({nm(m), ".done"}, 64'(done[m]), 64'(m_st[m] >= 2));
         chk({nm(m), ".fidx"}, 64'(first_idx[m]), 64'(m_fidx[m]));
         chk({nm(m), ".fexp"}, 64'(first_exp[m]), 64'(m_fexp[m]));
         chk({nm(m), ".fobs"}, 64'(first_obs[m]), 64'(m_fobs[m]));
      end
   endtask

   task automatic step();
      model_step(0, 1'b1);
      model_step(1, 1'b0);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input bit s, input bit ev, input logic [31:0] ed, input logic [31:0] em,
                        input bit ov, input logic [31:0] od, input bit et);
      start = s; exp_valid = ev; exp_data = ed; exp_mask = em;
      obs_valid = ov; obs_data = od; end_test = et;
      step();
   endtask

   task automatic nop(input bit et);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, et);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      nop(1'b0);
      reset = 1'b1;
   endtask

   initial begin
      logic [63:0] hd;
      bit          s;
      bit          ev;
      bit          ov;
      bit          et;
      logic [31:0] ed;
      logic [31:0] em;
      logic [31:0] od;
      n_chk = 0;
      n_pass = 0;
      reset = 1'b0;
      start = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_mask = '0;
      obs_valid = 1'b0; obs_data = '0; end_test = 1'b0;

      do_reset();
      chk("rst.state", 64'(state_o[0]), 64'd0);
      chk("rst.ready", 64'(exp_ready[0]), 64'd1);
      chk("rst.done", 64'(done[1]), 64'd0);

      // In-order matching stream, then drain to DONE.
      do_reset();
      for (int i = 11; i <= 16; i++) drive(1'b0, 1'b1, 32'(i), 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      for (int i = 11; i <= 16; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'(i), 1'b1);
      chk("seq.match", 64'(match_cnt[0]), 64'd6);
      chk("seq.done_early", 64'(done[0]), 64'd0);
      nop(1'b1);
      chk("seq.done", 64'(done[0]), 64'd1);
      chk("seq.mis", 64'(mis_cnt[0]), 64'd0);
      chk("seq.err", 64'(err_flag[0]), 64'd0);

      // Don't-care masks.
      do_reset();
      drive(1'b0, 1'b1, 32'd28, 32'd0, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b1, 32'd65536, 32'hFFFF_0000, 1'b0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0001_1234, 1'b0);
      chk("mask.match", 64'(match_cnt[1]), 64'd2);
      chk("mask.mis", 64'(mis_cnt[1]), 64'd0);

      // Single mismatch: one instance halts, the other keeps going.
      do_reset();
      drive(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b1, 32'd28, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b1, 32'd9, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd7, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd27, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd9, 1'b0);
      chk("halt.mis", 64'(mis_cnt[0]), 64'd1);
      chk("halt.fidx", 64'(first_idx[0]), 64'd1);
      chk("halt.fexp", 64'(first_exp[0]), 64'd28);
      chk("halt.fobs", 64'(first_obs[0]), 64'd27);
      chk("halt.state", 64'(state_o[0]), 64'd2);
      chk("halt.match", 64'(match_cnt[0]), 64'd1);
      nop(1'b1);
      chk("cont.state", 64'(state_o[1]), 64'd3);
      chk("cont.match", 64'(match_cnt[1]), 64'd2);
      chk("cont.mis", 64'(mis_cnt[1]), 64'd1);

      // Full FIFO, dropped pushes, then underflow.
      do_reset();
      for (int i = 0; i <= DEPTH; i++) drive(1'b0, 1'b1, 32'(100 + i), 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
      chk("full.ready", 64'(exp_ready[0]), 64'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      drive(1'b0, 1'b1, 32'd555, 32'hFFFF_FFFF, 1'b1, 32'd100, 1'b0);
      for (int i = 1; i < DEPTH; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'(100 + i), 1'b0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd555, 1'b0);
      chk("full.unf", 64'(unf_cnt[1]), 64'd1);
      chk("full.match", 64'(match_cnt[1]), 64'(DEPTH));

      // Reset mid-run overrides a same-cycle push and pop.
      do_reset();
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'(40 + i), 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'd40, 1'b0);
      reset = 1'b0;
      drive(1'b0, 1'b1, 32'd77, 32'hFFFF_FFFF, 1'b1, 32'd41, 1'b0);
      reset = 1'b1;
      chk("mrst.state", 64'(state_o[1]), 64'd0);
      chk("mrst.match", 64'(match_cnt[1]), 64'd0);
      chk("mrst.ready", 64'(exp_ready[1]), 64'd1);

      // Randomized episodes; observations mostly track the keep-going queue head.
      for (int ep = 0; ep < 25; ep++) begin
         do_reset();
         for (int c = 0; c < 60; c++) begin
            s  = (c == 2) || ($urandom % 10 == 0);
            ev = ($urandom % 2) == 1;
            ed = $urandom;
            em = ($urandom % 4 != 0) ? 32'hFFFF_FFFF : $urandom;
            ov = ($urandom % 2) == 1;
            od = $urandom;
            if (mq[1].size() > 0 && ($urandom % 6 != 0)) begin
               hd = mq[1][0];
               od = hd[63:32];
            end
            et = ($urandom % 8) == 0;
            if ($urandom % 80 == 0) reset = 1'b0;
            drive(s, ev, ed, em, ov, od, et);
            reset = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_result_checker.md
WB_RESULT_CHECKER -- requirements
Module: wb_result_checker

Interface
REQ-001 Parameter DATA_W, default 32, width of expected and observed writeback data.
REQ-002 Parameter DEPTH, default 32, expected-value FIFO entries; power of two, >= 2.
REQ-003 Parameter STOP_ON_ERR, default 1; 1 halts on first mismatch, 0 keeps checking and counts.
REQ-004 Parameter CNT_W, default 16, width of all counters.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse arming the checker.
REQ-008 exp_valid  in  1  expected entry offered.
REQ-009 exp_ready  out  1  FIFO can accept an entry; equals not-full.
REQ-010 exp_data  in  DATA_W  expected result value.
REQ-011 exp_mask  in  DATA_W  per-bit compare enable; 0 = don't-care bit.
REQ-012 obs_valid  in  1  writeback result retired this cycle.
REQ-013 obs_data  in  DATA_W  observed writeback result (result_w).
REQ-014 end_test  in  1  level; no further observations will arrive.
REQ-015 state_o  out  2  current FSM state encoding.
REQ-016 err_flag  out  1  sticky: any mismatch or underflow since start.
REQ-017 match_cnt / mis_cnt / unf_cnt  out  CNT_W each  saturating counts of matches, mismatches, underflows.
REQ-018 first_idx  out  CNT_W  observation index (0-based) of first mismatch.
REQ-019 first_exp / first_obs  out  DATA_W each  expected and observed values of first mismatch.
REQ-020 done  out  1  test finished cleanly or with errors.

Function
REQ-021 FSM states IDLE(0), RUN(1), HALT(2), DONE(3); reset enters IDLE.
REQ-022 IDLE->RUN on start; start in any other state is ignored.
REQ-023 FIFO accepts pushes in every state except HALT and DONE when exp_valid and exp_ready are both high.
REQ-024 exp_ready is low when the FIFO holds DEPTH entries, even if a pop occurs that cycle.
REQ-025 In RUN, obs_valid with the FIFO non-empty pops the head and compares ((obs_data ^ exp_data) & exp_mask) == 0.
REQ-026 A compare result updates the counters and flags on the edge following the obs_valid cycle (1-cycle latency, registered outputs).
REQ-027 obs_valid with the FIFO empty raises an underflow: unf_cnt increments and err_flag sets. No same-cycle bypass from a simultaneous push.
REQ-028 The observation index increments on every obs_valid in RUN, including underflows.
REQ-029 The first mismatch captures first_idx, first_exp and first_obs; later mismatches leave them unchanged.
REQ-030 With STOP_ON_ERR=1, a mismatch moves RUN->HALT.
REQ-031 HALT ignores obs_valid and pushes and holds all outputs; only reset exits HALT.
REQ-032 RUN->DONE when end_test is high, the FIFO is empty, and no compare is pending; done=1 in DONE and in HALT.
REQ-033 With end_test high but the FIFO non-empty, the FSM remains in RUN.
REQ-034 obs_valid in IDLE or DONE is ignored and not counted.
REQ-035 Counters saturate at all-ones and do not wrap.
REQ-036 FIFO read and write pointers are log2(DEPTH)+1 bits wide; the extra bit distinguishes full from empty across wrap-around.

Reset
REQ-037 Reset low on a clock edge clears the FIFO, pointers, counters, first_* registers, err_flag and done to 0, and sets state to IDLE; exp_ready=1.
REQ-038 Reset asserted mid-test overrides any same-cycle push, pop or compare.

Structure
REQ-039 Package wb_chk_pkg holds the FSM state encodings and the counter-saturation constant.
REQ-040 Sub-module wb_chk_fifo is a parametrised DEPTH x (2*DATA_W) synchronous FIFO with full/empty outputs, instantiated once.

Verification
REQ-041 Push 11,12,13,14,15,16 with mask all-ones, start, observe the same sequence -> match_cnt=6, mis_cnt=0, err_flag=0; with end_test high, done=1 one cycle after the last compare.
REQ-042 Push 28 with mask 0, observe 32'hDEADBEEF -> counted as a match; push 65536 with mask 32'hFFFF0000, observe 32'h0001_1234 -> match.
REQ-043 STOP_ON_ERR=1, push 7,28,9, observe 7,27,9 -> mis_cnt=1, first_idx=1, first_exp=28, first_obs=27, state HALT, third observation ignored (match_cnt=1).
REQ-044 STOP_ON_ERR=0, push 21,22,23, observe 21,0,23 -> match_cnt=2, mis_cnt=1, state DONE after end_test.
REQ-045 DEPTH pushes without observations -> exp_ready=0, extra push dropped; one observation with a simultaneous push still drops the push; obs_valid on an empty FIFO -> unf_cnt=1.
REQ-046 Reset low during RUN with 3 entries queued -> next cycle state IDLE, all counters 0, exp_ready=1.
